// File: rtl/bus_arbiter8_pkg.sv
// Shared widths, counter types and helpers for the 8-source bus arbiter.
// Latency: none (types and functions only).
// Backpressure: not applicable.
package bus_arbiter8_pkg;
    localparam int NUM_REQ         = 8;
    localparam int DATA_W          = 16;
    localparam int SEL_W           = 3;
    localparam int MAX_BURST_LIMIT = 16;
    localparam int CNT_W           = 5;

    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [SEL_W-1:0]   sel_t;
    typedef logic [NUM_REQ-1:0] req_vec_t;
    typedef logic [CNT_W-1:0]   cnt_t;

    function automatic req_vec_t onehot(input sel_t i);
        req_vec_t v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction
endpackage

// File: rtl/bus_arbiter8_if.sv
// Requester, mux-select and consumer handshake bundle of the shared bus.
// Latency: none (wiring only).
// Backpressure: consumer ready is carried here and honoured by the arbiter.
interface bus_arbiter8_if;
    import bus_arbiter8_pkg::*;

    req_vec_t                   req;
    req_vec_t                   lock;
    logic [NUM_REQ-1:0][DATA_W-1:0] d;
    sel_t                       sel;
    req_vec_t                   ack;
    data_t                      out_data;
    sel_t                       out_src;
    logic                       out_valid;
    logic                       ready;

    modport slave (
        input  req, lock, d, ready,
        output sel, ack, out_data, out_src, out_valid
    );

    modport master (
        output req, lock, d, ready,
        input  sel, ack, out_data, out_src, out_valid
    );
endinterface

// File: rtl/Mux8_3.sv
// Plain 16-bit 8:1 word multiplexer.
// Latency: combinational.
// Backpressure: not applicable.
module Mux8_3
    import bus_arbiter8_pkg::*;
(
    input  sel_t  S,
    input  data_t D0,
    input  data_t D1,
    input  data_t D2,
    input  data_t D3,
    input  data_t D4,
    input  data_t D5,
    input  data_t D6,
    input  data_t D7,
    output data_t Y
);
    always_comb begin
        Y = D0;
        case (S)
            3'd0: Y = D0;
            3'd1: Y = D1;
            3'd2: Y = D2;
            3'd3: Y = D3;
            3'd4: Y = D4;
            3'd5: Y = D5;
            3'd6: Y = D6;
            3'd7: Y = D7;
            default: Y = D0;
        endcase
    end
endmodule

// File: rtl/rr_pick8.sv
// Rotating-priority encoder: first set bit of eligible starting at ptr, wrapping.
// Latency: combinational.
// Backpressure: not applicable.
module rr_pick8
    import bus_arbiter8_pkg::*;
(
    input  req_vec_t eligible,
    input  sel_t     ptr,
    output logic     found,
    output sel_t     idx
);
    sel_t cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = ptr + SEL_W'(k);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end
endmodule

// File: rtl/bus_arbiter8.sv
// Round-robin arbiter with locked bursts feeding a one-entry output register.
// Latency: request seen in cycle N is presented (valid + ack) in cycle N+1.
// Backpressure: output held while valid && !ready; capture allowed on the accepting edge.
module bus_arbiter8
    import bus_arbiter8_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_arbiter8_if.slave bus
);
    localparam cnt_t BURST_MAX = cnt_t'(MAX_BURST);

    sel_t     ptr_q;
    sel_t     own_q;
    logic     own_vld_q;
    cnt_t     cnt_q;
    data_t    out_data_q;
    sel_t     out_src_q;
    logic     out_valid_q;
    req_vec_t ack_q;

    req_vec_t eligible;
    logic     ld;
    logic     locked;
    logic     stall;
    logic     lock_win;
    logic     pick_found;
    sel_t     pick_idx;
    sel_t     winner;
    logic     capture;
    sel_t     sel;
    data_t    mux_y;

    rr_pick8 u_pick (
        .eligible (eligible),
        .ptr      (ptr_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    // The owner's just-acked word is stale, so a locked owner idles one cycle
    // instead of letting someone else slip in mid-burst.
    always_comb begin
        ld       = !out_valid_q || bus.ready;
        eligible = bus.req & ~ack_q;
        locked   = own_vld_q && bus.lock[own_q] && (cnt_q < BURST_MAX);
        stall    = locked && ack_q[own_q];
        lock_win = locked && bus.req[own_q] && !ack_q[own_q];
        winner   = lock_win ? own_q : pick_idx;
        capture  = ld && !stall && (lock_win || pick_found);
        sel      = capture ? winner : '0;
    end

    Mux8_3 u_mux (
        .S  (sel),
        .D0 (bus.d[0]),
        .D1 (bus.d[1]),
        .D2 (bus.d[2]),
        .D3 (bus.d[3]),
        .D4 (bus.d[4]),
        .D5 (bus.d[5]),
        .D6 (bus.d[6]),
        .D7 (bus.d[7]),
        .Y  (mux_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= '0;
            own_q       <= '0;
            own_vld_q   <= 1'b0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            out_valid_q <= 1'b0;
            ack_q       <= '0;
        end else begin
            ack_q <= '0;
            if (capture) begin
                out_data_q  <= mux_y;
                out_src_q   <= winner;
                out_valid_q <= 1'b1;
                ack_q       <= onehot(winner);
                if (lock_win) begin
                    cnt_q <= cnt_q + cnt_t'(1);
                end else begin
                    // New owner; pointer moves past it so it is last in line next time.
                    own_q     <= winner;
                    own_vld_q <= 1'b1;
                    cnt_q     <= cnt_t'(1);
                    ptr_q     <= winner + sel_t'(1);
                end
            end else if (out_valid_q && bus.ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.sel       = sel;
    assign bus.ack       = ack_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_src   = out_src_q;
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_bus_arbiter8.sv
// Directed bench for bus_arbiter8: reset, round robin, wrap, backpressure, lock burst/release.
module tb_bus_arbiter8;
    import bus_arbiter8_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    bus_arbiter8_if bus ();

    bus_arbiter8 #(.MAX_BURST(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req   = '0;
        bus.lock  = '0;
        bus.ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) bus.d[i] = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b want 0", bus.out_valid); end
        n_checks++; if (bus.ack !== 8'h00) begin n_fail++; $display("FAIL rst_ack got %h want 00", bus.ack); end
        n_checks++; if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL rst_data got %h want 0000", bus.out_data); end
        n_checks++; if (bus.out_src !== 3'd0) begin n_fail++; $display("FAIL rst_src got %0d want 0", bus.out_src); end
        tick();
        rst_n = 1'b1;
        bus.req   = 8'hFF;
        bus.ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) bus.d[i] = 16'hC000 + 16'(i);
        tick();
        n_checks++; if (bus.ack !== 8'h01 || bus.out_data !== 16'hC000) begin n_fail++; $display("FAIL pre_rst_capture got ack %h data %h want 01 C000", bus.ack, bus.out_data); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %0b want 0", bus.out_valid); end
        n_checks++; if (bus.ack !== 8'h00) begin n_fail++; $display("FAIL mid_rst_ack got %h want 00", bus.ack); end
        n_checks++; if (bus.out_data !== 16'h0000) begin n_fail++; $display("FAIL mid_rst_data got %h want 0000", bus.out_data); end
        tick();
        idle_inputs();
        rst_n    = 1'b1;
        bus.req  = 8'h01;
        bus.d[0] = 16'hA5A5;
        tick();
        n_checks++; if (bus.out_data !== 16'hA5A5) begin n_fail++; $display("FAIL post_rst_data got %h want A5A5", bus.out_data); end
        n_checks++; if (bus.out_src !== 3'd0) begin n_fail++; $display("FAIL post_rst_src got %0d want 0", bus.out_src); end
        n_checks++; if (bus.ack !== 8'h01) begin n_fail++; $display("FAIL post_rst_ack got %h want 01", bus.ack); end
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL post_rst_valid got %0b want 1", bus.out_valid); end
        bus.req = 8'h00;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0 || bus.ack !== 8'h00) begin n_fail++; $display("FAIL drain_valid got %0b ack %h want 0 00", bus.out_valid, bus.ack); end
    endtask

    task automatic test_round_robin();
        int       gen [NUM_REQ];
        logic [7:0] seen;
        int       exp_i;
        do_reset();
        seen = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            gen[i]   = 0;
            bus.d[i] = {4'(i), 12'h000};
        end
        bus.req = 8'hFF;
        #1;
        n_checks++; if (bus.sel !== 3'd0) begin n_fail++; $display("FAIL rr_sel0 got %0d want 0", bus.sel); end
        for (int k = 0; k < 9; k++) begin
            tick();
            exp_i = k % 8;
            n_checks++; if (bus.out_src !== 3'(exp_i) || bus.ack !== (8'h01 << exp_i)) begin n_fail++; $display("FAIL rr_grant%0d got src %0d ack %h want %0d", k, bus.out_src, bus.ack, exp_i); end
            n_checks++; if (bus.out_data !== {4'(exp_i), 8'h00, 4'(k / 8)}) begin n_fail++; $display("FAIL rr_data%0d got %h", k, bus.out_data); end
            if (k < 8) seen = seen | bus.ack;
            if (k == 7) begin
                n_checks++; if (seen !== 8'hFF) begin n_fail++; $display("FAIL rr_unique got %h want FF", seen); end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (bus.ack[i]) begin
                    gen[i]++;
                    bus.d[i] = {4'(i), 8'h00, 4'(gen[i])};
                end
            end
            if (k == 2) begin
                #1;
                n_checks++; if (bus.sel !== 3'd3) begin n_fail++; $display("FAIL rr_sel3 got %0d want 3", bus.sel); end
            end
        end
    endtask

    task automatic test_wrap();
        bus.req  = 8'h80;
        bus.d[7] = 16'h7777;
        tick();
        n_checks++; if (bus.out_src !== 3'd7 || bus.out_data !== 16'h7777) begin n_fail++; $display("FAIL wrap_g7 got %0d %h want 7 7777", bus.out_src, bus.out_data); end
        bus.req  = 8'h81;
        bus.d[0] = 16'h0A0A;
        bus.d[7] = 16'h7778;
        tick();
        n_checks++; if (bus.out_src !== 3'd0 || bus.out_data !== 16'h0A0A) begin n_fail++; $display("FAIL wrap_g0 got %0d %h want 0 0A0A", bus.out_src, bus.out_data); end
        bus.d[0] = 16'h0A0B;
        tick();
        n_checks++; if (bus.out_src !== 3'd7 || bus.out_data !== 16'h7778) begin n_fail++; $display("FAIL wrap_g7b got %0d %h want 7 7778", bus.out_src, bus.out_data); end
        bus.req = 8'h00;
        tick();
    endtask

    task automatic test_backpressure();
        bus.ready = 1'b0;
        bus.req   = 8'h08;
        bus.d[3]  = 16'h3333;
        tick();
        n_checks++; if (bus.out_data !== 16'h3333 || bus.ack !== 8'h08) begin n_fail++; $display("FAIL bp_first got %h ack %h want 3333 08", bus.out_data, bus.ack); end
        bus.req  = 8'h04;
        bus.d[2] = 16'h2222;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 16'h3333 || bus.ack !== 8'h00) begin n_fail++; $display("FAIL bp_hold%0d got v%0b %h ack %h want v1 3333 00", c, bus.out_valid, bus.out_data, bus.ack); end
        end
        bus.ready = 1'b1;
        #1;
        n_checks++; if (bus.sel !== 3'd2) begin n_fail++; $display("FAIL bp_sel got %0d want 2", bus.sel); end
        tick();
        n_checks++; if (bus.out_data !== 16'h2222 || bus.out_src !== 3'd2 || bus.ack !== 8'h04) begin n_fail++; $display("FAIL bp_release got %h src %0d ack %h want 2222 2 04", bus.out_data, bus.out_src, bus.ack); end
        bus.req = 8'h00;
        tick();
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %0b want 0", bus.out_valid); end
    endtask

    task automatic test_locked_burst();
        logic [7:0]  exp_ack [8] = '{8'h02, 8'h00, 8'h02, 8'h00, 8'h02, 8'h00, 8'h02, 8'h20};
        logic [15:0] exp_dat [8] = '{16'h1100, 16'h0, 16'h1101, 16'h0, 16'h1102, 16'h0, 16'h1103, 16'h5555};
        int gen1;
        do_reset();
        gen1     = 0;
        bus.req  = 8'h22;
        bus.lock = 8'h02;
        bus.d[1] = 16'h1100;
        bus.d[5] = 16'h5555;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++; if (bus.ack !== exp_ack[c] || bus.out_valid !== (exp_ack[c] != 8'h00)) begin n_fail++; $display("FAIL burst_c%0d got ack %h v%0b want %h", c, bus.ack, bus.out_valid, exp_ack[c]); end
            if (exp_ack[c] != 8'h00) begin
                n_checks++; if (bus.out_data !== exp_dat[c]) begin n_fail++; $display("FAIL burst_data%0d got %h want %h", c, bus.out_data, exp_dat[c]); end
            end
            if (bus.ack[1]) begin
                gen1++;
                bus.d[1] = 16'h1100 + 16'(gen1);
            end
        end
        bus.req  = 8'h00;
        bus.lock = 8'h00;
        tick();
    endtask

    task automatic test_lock_release();
        logic [7:0]  exp_ack [5] = '{8'h08, 8'h00, 8'h08, 8'h00, 8'h40};
        logic [15:0] exp_dat [5] = '{16'h3300, 16'h0, 16'h3301, 16'h0, 16'h6666};
        int gen3;
        do_reset();
        gen3     = 0;
        bus.req  = 8'h48;
        bus.lock = 8'h08;
        bus.d[3] = 16'h3300;
        bus.d[6] = 16'h6666;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++; if (bus.ack !== exp_ack[c]) begin n_fail++; $display("FAIL release_c%0d got ack %h want %h", c, bus.ack, exp_ack[c]); end
            if (exp_ack[c] != 8'h00) begin
                n_checks++; if (bus.out_data !== exp_dat[c]) begin n_fail++; $display("FAIL release_data%0d got %h want %h", c, bus.out_data, exp_dat[c]); end
            end
            if (bus.ack[3]) begin
                gen3++;
                bus.d[3] = 16'h3300 + 16'(gen3);
                if (gen3 == 2) bus.req[3] = 1'b0;
            end
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_wrap();
        test_backpressure();
        test_locked_burst();
        test_lock_release();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
